// File: rtl/alu_uart_pkg.sv
// Shared types and constants for the UART-to-ALU byte sequencer.
package alu_uart_pkg;

    localparam int BYTE_WIDTH     = 8;
    localparam int OPERATOR_WIDTH = 6;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        COMPUTE = 3'd3,
        CAPTURE = 3'd4,
        SEND    = 3'd5
    } state_e;

endpackage

// File: rtl/alu_uart_if.sv
// Bundle between the sequencer, the UART RX/TX pair and the ALU front end.
// Handshake: rx_valid is a one-cycle pulse with no back-pressure; a TX byte moves
// on a posedge where tx_valid && tx_ready, and tx_valid/tx_data hold until then.
interface alu_uart_if #(parameter int DATA_WIDTH = 16);
    import alu_uart_pkg::*;

    logic [BYTE_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] resultado;
    logic [DATA_WIDTH-1:0] dato;
    logic                  select_A;
    logic                  select_B;
    logic                  select_op;
    logic                  select_resultado;
    logic [BYTE_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  busy;
    logic                  rx_drop;
    logic [2:0]            state;

    modport master (
        input  rx_data, rx_valid, resultado, tx_ready,
        output dato, select_A, select_B, select_op, select_resultado,
        output tx_data, tx_valid, busy, rx_drop, state
    );

    modport slave (
        output rx_data, rx_valid, resultado, tx_ready,
        input  dato, select_A, select_B, select_op, select_resultado,
        input  tx_data, tx_valid, busy, rx_drop, state
    );

endinterface

// File: rtl/alu_uart_interface_byte_serializer.sv
// Parallel-load shifter that emits a word LSB byte first over valid/ready.
module byte_serializer
    import alu_uart_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  tx_ready,
    output logic [BYTE_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  done
);

    localparam int NB = DATA_WIDTH / BYTE_WIDTH;
    localparam int CW = $clog2(NB) + 1;

    logic [DATA_WIDTH-1:0] shreg;
    logic [CW-1:0]         remaining;

    assign tx_data = shreg[BYTE_WIDTH-1:0];
    // Combinational so the owner can leave SEND on the same edge as the last accept.
    assign done    = tx_valid && tx_ready && (remaining == CW'(1));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            shreg     <= '0;
            remaining <= '0;
            tx_valid  <= 1'b0;
        end else if (load) begin
            shreg     <= data;
            remaining <= CW'(NB);
            tx_valid  <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            shreg     <= shreg >> BYTE_WIDTH;
            remaining <= remaining - 1'b1;
            if (remaining == CW'(1)) tx_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_uart_interface.sv
// Sequencer: assembles A, B and opcode from UART bytes, strobes them into the ALU,
// triggers the result capture and streams the result back out LSB first.
module alu_uart_interface
    import alu_uart_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    alu_uart_if.master bus
);

    localparam int NB = DATA_WIDTH / BYTE_WIDTH;
    localparam int CW = $clog2(NB) + 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);

    localparam logic [2:0] ST_LOAD_A  = 3'(LOAD_A);
    localparam logic [2:0] ST_LOAD_B  = 3'(LOAD_B);
    localparam logic [2:0] ST_LOAD_OP = 3'(LOAD_OP);
    localparam logic [2:0] ST_COMPUTE = 3'(COMPUTE);
    localparam logic [2:0] ST_CAPTURE = 3'(CAPTURE);
    localparam logic [2:0] ST_SEND    = 3'(SEND);

    if (DATA_WIDTH % BYTE_WIDTH != 0 || DATA_WIDTH < BYTE_WIDTH || BYTE_WIDTH <= OPERATOR_WIDTH) begin : g_bad_width
        $error("alu_uart_interface: DATA_WIDTH must be a non-zero multiple of 8");
    end

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d, merged;
    logic [DATA_WIDTH-1:0] dato_q, dato_d;
    logic                  sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic                  sel_op_q, sel_op_d, sel_res_q, sel_res_d;
    logic                  load_q, load_d, drop_q, drop_d, busy_q;
    logic                  tx_accept, tx_done;

    assign tx_accept = bus.tx_valid && bus.tx_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        dato_d    = dato_q;
        sel_a_d   = 1'b0;
        sel_b_d   = 1'b0;
        sel_op_d  = 1'b0;
        sel_res_d = 1'b0;
        load_d    = 1'b0;
        drop_d    = 1'b0;
        merged    = asm_q;
        merged[BYTE_WIDTH*int'(cnt_q) +: BYTE_WIDTH] = bus.rx_data;

        case (state_q)
            ST_LOAD_A, ST_LOAD_B: begin
                if (bus.rx_valid) begin
                    if (cnt_q == LAST_BYTE) begin
                        dato_d = merged;
                        asm_d  = '0;
                        cnt_d  = '0;
                        if (state_q == ST_LOAD_A) begin
                            sel_a_d = 1'b1;
                            state_d = ST_LOAD_B;
                        end else begin
                            sel_b_d = 1'b1;
                            state_d = ST_LOAD_OP;
                        end
                    end else begin
                        asm_d = merged;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_LOAD_OP: begin
                if (bus.rx_valid) begin
                    dato_d   = DATA_WIDTH'(bus.rx_data);
                    sel_op_d = 1'b1;
                    state_d  = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                sel_res_d = 1'b1;
                drop_d    = bus.rx_valid;
                state_d   = ST_CAPTURE;
            end
            // The load is registered once more so resultado is sampled a full cycle
            // after the ALU's negedge capture.
            ST_CAPTURE: begin
                load_d  = 1'b1;
                drop_d  = bus.rx_valid;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                drop_d = bus.rx_valid;
                if (tx_done) begin
                    cnt_d   = '0;
                    state_d = ST_LOAD_A;
                end else if (tx_accept) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_LOAD_A;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_LOAD_A;
            cnt_q     <= '0;
            asm_q     <= '0;
            dato_q    <= '0;
            sel_a_q   <= 1'b0;
            sel_b_q   <= 1'b0;
            sel_op_q  <= 1'b0;
            sel_res_q <= 1'b0;
            load_q    <= 1'b0;
            drop_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            asm_q     <= asm_d;
            dato_q    <= dato_d;
            sel_a_q   <= sel_a_d;
            sel_b_q   <= sel_b_d;
            sel_op_q  <= sel_op_d;
            sel_res_q <= sel_res_d;
            load_q    <= load_d;
            drop_q    <= drop_d;
            busy_q    <= !(state_d == ST_LOAD_A && cnt_d == '0);
        end
    end

    byte_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_serializer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (load_q),
        .data     (bus.resultado),
        .tx_ready (bus.tx_ready),
        .tx_data  (bus.tx_data),
        .tx_valid (bus.tx_valid),
        .done     (tx_done)
    );

    assign bus.dato             = dato_q;
    assign bus.select_A         = sel_a_q;
    assign bus.select_B         = sel_b_q;
    assign bus.select_op        = sel_op_q;
    assign bus.select_resultado = sel_res_q;
    assign bus.busy             = busy_q;
    assign bus.rx_drop          = drop_q;
    assign bus.state            = state_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Bench for alu_uart_interface: frame table, timing sequences, random frames, 8-bit build.
module tb_alu_uart_interface;
  import alu_uart_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  alu_uart_if #(.DATA_WIDTH(16)) bus ();
  alu_uart_if #(.DATA_WIDTH(8))  bus8 ();

  alu_uart_interface #(.DATA_WIDTH(16)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  alu_uart_interface #(.DATA_WIDTH(8))  dut8 (.clock(clock), .reset_n(reset_n), .bus(bus8));

  typedef struct {
    logic [7:0]  b0, b1, b2, b3, b4;
    logic [15:0] res;
    logic [15:0] exp_a, exp_b, exp_op;
    logic [7:0]  exp_tx0, exp_tx1;
  } vec_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] val;
  } strobe_t;

  vec_t       tbl [12];
  logic [7:0] exp_q [$];
  strobe_t    exp_s [$];
  int         acc_cyc [$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         drop_cnt = 0;
  int         sel_a_cyc, sel_op_cyc, sel_res_cyc, txv_rise_cyc;
  logic       prev_txv = 1'b0;

  logic [1:0] ev8_kind [$];
  logic [7:0] ev8_dato [$];
  int         ev8_cyc [$];
  logic [7:0] tx8 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: little-endian operand words and LSB-first result bytes.
  function automatic vec_t make_vec(input logic [7:0] a0, a1, b0, b1, op, input logic [15:0] res);
    vec_t v;
    int   a_val, b_val;
    v.b0 = a0; v.b1 = a1; v.b2 = b0; v.b3 = b1; v.b4 = op; v.res = res;
    a_val = int'(a1) * 256 + int'(a0);
    b_val = int'(b1) * 256 + int'(b0);
    v.exp_a   = 16'(a_val);
    v.exp_b   = 16'(b_val);
    v.exp_op  = 16'(int'(op));
    v.exp_tx0 = 8'(int'(res) % 256);
    v.exp_tx1 = 8'(int'(res) / 256);
    return v;
  endfunction

  always @(negedge clock) begin : monitor
    logic [1:0] k;
    strobe_t    e;
    if (reset_n) begin
      if (bus.select_A || bus.select_B || bus.select_op) begin
        k = bus.select_A ? 2'd0 : (bus.select_B ? 2'd1 : 2'd2);
        if (exp_s.size() == 0) check("strobe_unexpected", 32'(k), 32'd3);
        else begin
          e = exp_s.pop_front();
          check("strobe_kind", 32'(k), 32'(e.kind));
          check("strobe_dato", 32'(bus.dato), 32'(e.val));
        end
      end
      if ($countones({bus.select_A, bus.select_B, bus.select_op, bus.select_resultado}) > 1)
        check("strobe_onehot", 32'($countones({bus.select_A, bus.select_B, bus.select_op, bus.select_resultado})), 32'd1);
      if (bus.select_A) sel_a_cyc = cyc;
      if (bus.select_op) sel_op_cyc = cyc;
      if (bus.select_resultado) sel_res_cyc = cyc;
      if (bus.tx_valid && !prev_txv) txv_rise_cyc = cyc;
      if (bus.tx_valid && bus.tx_ready) begin
        acc_cyc.push_back(cyc);
        if (exp_q.size() == 0) check("tx_unexpected", 32'(bus.tx_data), 32'h100);
        else check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
      end
      if (bus.rx_drop) drop_cnt++;
      if (bus8.select_A)  begin ev8_kind.push_back(2'd0); ev8_dato.push_back(bus8.dato); ev8_cyc.push_back(cyc); end
      if (bus8.select_B)  begin ev8_kind.push_back(2'd1); ev8_dato.push_back(bus8.dato); ev8_cyc.push_back(cyc); end
      if (bus8.select_op) begin ev8_kind.push_back(2'd2); ev8_dato.push_back(bus8.dato); ev8_cyc.push_back(cyc); end
      if (bus8.tx_valid && bus8.tx_ready) tx8.push_back(bus8.tx_data);
    end
    prev_txv = bus.tx_valid;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send8(input logic [7:0] b);
    bus8.rx_data = b;
    bus8.rx_valid = 1'b1;
    tick();
    bus8.rx_valid = 1'b0;
  endtask

  task automatic push_exp(input vec_t v);
    exp_s.push_back({2'd0, v.exp_a});
    exp_s.push_back({2'd1, v.exp_b});
    exp_s.push_back({2'd2, v.exp_op});
    exp_q.push_back(v.exp_tx0);
    exp_q.push_back(v.exp_tx1);
  endtask

  task automatic send_frame(input vec_t v, input int gap_max);
    logic [7:0] bs [5];
    bs = '{v.b0, v.b1, v.b2, v.b3, v.b4};
    bus.resultado = v.res;
    for (int i = 0; i < 5; i++) begin
      send_byte(bs[i]);
      if (i == 0) check("busy_after_first_byte", 32'(bus.busy), 32'd1);
      if (i < 4) repeat ($urandom_range(0, gap_max)) tick();
    end
  endtask

  task automatic wait_done(input int ready_pct);
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 200) begin
      bus.tx_ready = ($urandom_range(0, 99) < ready_pct);
      tick();
      n++;
    end
    check("frame_tx_left", 32'(exp_q.size()), 32'd0);
    check("frame_strobes_left", 32'(exp_s.size()), 32'd0);
    check("frame_busy_idle", 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_txv();
    int n = 0;
    while (!bus.tx_valid && n < 20) begin
      tick();
      n++;
    end
    check("tx_valid_seen", 32'(bus.tx_valid), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dato"}, 32'(bus.dato), 32'd0);
    check({tag, "_strobes"}, 32'({bus.select_A, bus.select_B, bus.select_op, bus.select_resultado}), 32'd0);
    check({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
    check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_rx_drop"}, 32'(bus.rx_drop), 32'd0);
    check({tag, "_state"}, 32'(bus.state), 32'(LOAD_A));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int p_a, p_op;
    bus.rx_data = '0;  bus.rx_valid = 1'b0; bus.resultado = '0; bus.tx_ready = 1'b0;
    bus8.rx_data = '0; bus8.rx_valid = 1'b0; bus8.resultado = '0; bus8.tx_ready = 1'b0;

    tbl[0] = '{b0:8'h34, b1:8'h12, b2:8'h05, b3:8'h00, b4:8'h20, res:16'h1239,
               exp_a:16'h1234, exp_b:16'h0005, exp_op:16'h0020, exp_tx0:8'h39, exp_tx1:8'h12};
    tbl[1] = '{b0:8'hFF, b1:8'hFF, b2:8'h00, b3:8'h80, b4:8'h3F, res:16'hA55A,
               exp_a:16'hFFFF, exp_b:16'h8000, exp_op:16'h003F, exp_tx0:8'h5A, exp_tx1:8'hA5};
    tbl[2] = '{b0:8'h00, b1:8'h00, b2:8'h00, b3:8'h00, b4:8'hFF, res:16'h0000,
               exp_a:16'h0000, exp_b:16'h0000, exp_op:16'h00FF, exp_tx0:8'h00, exp_tx1:8'h00};
    for (int i = 3; i < 12; i++)
      tbl[i] = make_vec(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                        8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                        8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)));

    // Reset state
    repeat (3) tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick();

    // Basic frame, back-to-back bytes, tx_ready high: strobe and TX timing
    push_exp(tbl[0]);
    bus.tx_ready = 1'b1;
    bus.resultado = tbl[0].res;
    acc_cyc.delete();
    send_byte(tbl[0].b0);
    send_byte(tbl[0].b1);
    p_a = cyc;
    send_byte(tbl[0].b2);
    send_byte(tbl[0].b3);
    send_byte(tbl[0].b4);
    p_op = cyc;
    wait_done(100);
    check("sel_a_latency", 32'(sel_a_cyc - p_a), 32'd0);
    check("sel_op_latency", 32'(sel_op_cyc - p_op), 32'd0);
    check("sel_res_latency", 32'(sel_res_cyc - p_op), 32'd1);
    check("tx_valid_latency", 32'(txv_rise_cyc - p_op), 32'd3);
    check("tx_accepts", 32'(acc_cyc.size()), 32'd2);
    if (acc_cyc.size() == 2) check("tx_consecutive", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);

    // Backpressure: first byte held for 10 cycles
    push_exp(tbl[0]);
    bus.tx_ready = 1'b0;
    send_frame(tbl[0], 0);
    wait_txv();
    for (int i = 0; i < 10; i++) begin
      check("bp_tx_data", 32'(bus.tx_data), 32'(tbl[0].exp_tx0));
      check("bp_tx_valid", 32'(bus.tx_valid), 32'd1);
      tick();
    end
    wait_done(100);

    // Drop during SEND, then an unaffected frame
    push_exp(tbl[0]);
    bus.tx_ready = 1'b0;
    send_frame(tbl[0], 1);
    wait_txv();
    drop_cnt = 0;
    send_byte(8'hAA);
    repeat (3) tick();
    check("drop_pulses", 32'(drop_cnt), 32'd1);
    check("drop_tx_data", 32'(bus.tx_data), 32'(tbl[0].exp_tx0));
    check("drop_state", 32'(bus.state), 32'(SEND));
    wait_done(100);
    push_exp(tbl[1]);
    send_frame(tbl[1], 0);
    wait_done(100);

    // Reset held 3 cycles mid-LOAD_B, then a full frame
    exp_s.push_back({2'd0, tbl[0].exp_a});
    send_byte(tbl[0].b0);
    send_byte(tbl[0].b1);
    send_byte(tbl[0].b2);
    check("midb_state", 32'(bus.state), 32'(LOAD_B));
    reset_n = 1'b0;
    repeat (3) tick();
    check_reset_outputs("midb_reset");
    reset_n = 1'b1;
    check("midb_strobes_left", 32'(exp_s.size()), 32'd0);
    push_exp(tbl[2]);
    send_frame(tbl[2], 1);
    wait_done(100);

    // Reset during SEND withdraws the pending byte
    exp_s.push_back({2'd0, tbl[1].exp_a});
    exp_s.push_back({2'd1, tbl[1].exp_b});
    exp_s.push_back({2'd2, tbl[1].exp_op});
    bus.tx_ready = 1'b0;
    send_frame(tbl[1], 0);
    wait_txv();
    reset_n = 1'b0;
    tick();
    check("send_reset_tx_valid", 32'(bus.tx_valid), 32'd0);
    reset_n = 1'b1;
    tick();

    // Randomized frames with random gaps and random tx_ready
    for (int i = 3; i < 12; i++) begin
      push_exp(tbl[i]);
      send_frame(tbl[i], 2);
      wait_done(60);
    end

    // 8-bit build: one byte per operand, single TX byte
    ev8_kind.delete(); ev8_dato.delete(); ev8_cyc.delete(); tx8.delete();
    bus8.resultado = 8'h00;
    bus8.tx_ready = 1'b1;
    send8(8'h0F);
    p_a = cyc;
    send8(8'hF0);
    p_op = cyc;
    send8(8'h24);
    for (int n = 0; n < 20 && tx8.size() == 0; n++) tick();
    tick();
    check("w8_events", 32'(ev8_kind.size()), 32'd3);
    if (ev8_kind.size() == 3) begin
      check("w8_kind_a", 32'(ev8_kind[0]), 32'd0);
      check("w8_dato_a", 32'(ev8_dato[0]), 32'h0F);
      check("w8_cyc_a", 32'(ev8_cyc[0] - p_a), 32'd0);
      check("w8_kind_b", 32'(ev8_kind[1]), 32'd1);
      check("w8_dato_b", 32'(ev8_dato[1]), 32'hF0);
      check("w8_cyc_b", 32'(ev8_cyc[1] - p_op), 32'd0);
      check("w8_kind_op", 32'(ev8_kind[2]), 32'd2);
      check("w8_dato_op", 32'(ev8_dato[2]), 32'h24);
    end
    check("w8_tx_count", 32'(tx8.size()), 32'd1);
    if (tx8.size() == 1) check("w8_tx_byte", 32'(tx8[0]), 32'h00);
    check("w8_busy_idle", 32'(bus8.busy), 32'd0);

    check("final_tx_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_uart_interface.md
# alu_uart_interface

Byte-stream sequencer that drives the switch-style ALU front end (`dato` plus `select_A`/`select_B`/`select_op`/`select_resultado` strobes) from a UART receiver and returns the result to a UART transmitter. It assembles operand A, operand B and the opcode from received bytes and issues one-cycle load strobes. It then triggers the result capture and serializes the result back out, least significant byte first. It sits between the UART RX/TX pair and the ALU top.

## Interface
- `DATA_WIDTH`, 16, operand/result width; multiple of 8, ≥ 8.
- `BYTE_WIDTH`, 8, UART byte width (fixed).
- `clock`  in  1  single system clock, all logic on posedge.
- `reset_n`  in  1  synchronous, active-low reset.
- `rx_data`  in  8  byte from UART receiver.
- `rx_valid`  in  1  one-cycle pulse, `rx_data` valid.
- `resultado`  in  DATA_WIDTH  ALU top registered result.
- `dato`  out  DATA_WIDTH  shared data bus to ALU top.
- `select_A`, `select_B`, `select_op`, `select_resultado`  out  1 each  one-cycle load strobes.
- `tx_data`  out  8  byte to UART transmitter.
- `tx_valid`  out  1  `tx_data` valid; held until accepted.
- `tx_ready`  in  1  transmitter accepts on posedge with `tx_valid`.
- `busy`  out  1  high outside LOAD_A with byte count 0.
- `rx_drop`  out  1  one-cycle pulse when an `rx_valid` byte is discarded.

## Operation
- NB = DATA_WIDTH/8 bytes per operand; operands are little-endian (first byte = bits 7:0).
- States:
  - LOAD_A, LOAD_B: collect NB bytes each into an assembly register.
  - LOAD_OP: 1 byte.
  - COMPUTE: 1 cycle.
  - CAPTURE: 1 cycle.
  - SEND: NB bytes.
  - Then back to LOAD_A.
- Byte counter `cnt` (width clog2(NB)+1) increments per accepted byte; clears on state change.
- LOAD_A/LOAD_B transition: on the last byte, `dato` gets the assembled word and `select_A`/`select_B` pulses for one cycle. Next state is LOAD_B/LOAD_OP.
- LOAD_OP transition: on the op byte, `dato` gets the zero-extended byte (the ALU uses bits 5:0; bits 7:6 are passed unchanged) and `select_op` pulses. Next state is COMPUTE.
- COMPUTE: assert `select_resultado` for one cycle. The ALU captures on the negedge of that cycle.
- CAPTURE: sample `resultado` into the TX shift register and go to SEND.
- SEND: `tx_data` = shift register bits 7:0, with `tx_valid` high. On `tx_valid && tx_ready`, shift right by 8 and increment `cnt`. After NB accepts, drop `tx_valid` and go to LOAD_A.
- `rx_valid` in COMPUTE, CAPTURE or SEND: byte discarded, `rx_drop` pulses the next cycle, no state change.
- `dato` holds its last driven value between strobes; it does not change while any strobe is high.
- At most one select strobe is high in any cycle.

## Timing
- Reset (`reset_n` low at posedge): state LOAD_A, `cnt` 0, `dato` 0, all strobes 0, `tx_valid` 0, `tx_data` 0, `busy` 0, `rx_drop` 0.
- Reset mid-operation: a partial operand is discarded and an in-flight TX byte is withdrawn (`tx_valid` low the next cycle).
- All outputs are registered.
- Last operand byte at posedge t: strobe and `dato` valid in cycle t+1.
- Op byte at t:
  - `select_op` in t+1.
  - `select_resultado` in t+2.
  - `resultado` sampled at posedge t+3.
  - First `tx_valid` in t+4.
- Back-to-back `rx_valid` every cycle is accepted in load states; there is no minimum byte spacing.
- `tx_ready` held high: one byte per cycle; the final transfer returns to LOAD_A the following cycle.
- `tx_ready` low: `tx_data`/`tx_valid` stable indefinitely.
- A new frame can begin the cycle after the final TX accept.

## Structure
- Package `alu_uart_pkg` holds:
  - state enum (LOAD_A, LOAD_B, LOAD_OP, COMPUTE, CAPTURE, SEND);
  - `BYTE_WIDTH` = 8;
  - `OPERATOR_WIDTH` = 6.
- One sub-module: `byte_serializer` (parallel load of DATA_WIDTH, valid/ready byte output, done pulse), used for SEND.
- Byte assembly stays inline in the FSM.
- Elaboration check: DATA_WIDTH % 8 == 0.

## Test plan
- Reset: hold `reset_n` low 3 cycles mid-LOAD_B → all outputs 0, then a full new frame completes correctly.
- Basic frame: RX 0x34,0x12, 0x05,0x00, 0x20; `resultado` tied to 0x1239 → strobe sequence and timing as specified:
  - `select_A` with `dato`=0x1234;
  - `select_B` with `dato`=0x0005;
  - `select_op` with `dato`=0x0020;
  - `select_resultado` one cycle;
  - TX 0x39 then 0x12.
- Backpressure: same frame, `tx_ready` low 10 cycles then high → 0x39 held stable 10 cycles, no byte lost or duplicated.
- Drop: inject `rx_valid` 0xAA during SEND → `rx_drop` pulses once, TX bytes unchanged, next frame unaffected.
- Back-to-back: five RX bytes on consecutive cycles, `tx_ready` high → `tx_valid` first asserted exactly 4 cycles after the op byte, and the two TX bytes go out on consecutive cycles.
- DATA_WIDTH=8 build: RX 0x0F, 0xF0, 0x24, `resultado`=0x00 → `select_A`/`select_B` after one byte each, single TX byte 0x00.
